crtc_mode_loader: RTL
=====================

Name: crtc_mode_loader

Overview:
- Sequencer that programs crtc6845 timing registers (R0–R7, R9–R13) from a built-in mode table, using the CRTC's own two-phase ISA register interface.
- Sits between the host ISA decode and the CRTC bus port, and muxes host register traffic with loader traffic.
- Stalls the host while loading, then restores the CRTC address register so host data writes resume at the host-selected index.

Parameters:
- GAP_CYCLES, 1, idle cycles inserted after each data write (0–7).
- NUM_MODES, 4, number of mode table entries; mode_sel width is clog2(NUM_MODES).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to load the mode selected by mode_sel
- mode_sel  in  2  mode index, sampled when start is accepted
- host_cs, host_a0, host_write, host_read  in  1 each  host ISA strobes for the CRTC
- host_bus  in  8  host write data
- host_lock  in  1  host lock request
- host_wait  out  1  host must hold its access (high whenever busy)
- crtc_cs, crtc_a0, crtc_write, crtc_read  out  1 each  strobes to the CRTC
- crtc_bus  out  8  write data to the CRTC
- crtc_lock  out  1  lock to the CRTC
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the load completes

Behaviour:
- Reset (asynchronous): state=IDLE, idx=0, gap_cnt=0, shadow=0, pending=0, mode_r=0. All registered outputs are 0: busy, done, host_wait.
- IDLE passthrough (combinational): crtc_* = host_*, crtc_lock = host_lock.
  - A host address write (host_cs & host_write & ~host_a0) sets shadow <= host_bus[4:0].
- Start acceptance:
  - start in IDLE sets pending=1 and mode_r=mode_sel.
  - Leave IDLE on the first cycle where pending=1 and host_cs=0. A host access in the same cycle wins, and the load begins the next cycle.
  - start while busy is ignored. A second start while pending=1 overwrites mode_r.
- Write sequence: 13 entries, idx 0..12 mapping to registers R0,R1,R2,R3,R4,R5,R6,R7,R9,R10,R11,R12,R13. R8 is skipped. R12 and R13 are written as 0.
- States:
  - IDLE.
  - ADDR: cs=1, write=1, a0=0, bus={3'b0, reg(idx)}.
  - DATA: cs=1, write=1, a0=1, bus=table[mode_r][idx].
  - GAP: strobes 0 for GAP_CYCLES cycles, counted by gap_cnt. Skipped when GAP_CYCLES=0.
  - RESTORE: cs=1, write=1, a0=0, bus={3'b0, shadow}.
  - DONE: done=1, strobes 0.
- Transitions:
  - IDLE → ADDR.
  - ADDR → DATA.
  - DATA → GAP (or the next ADDR when GAP_CYCLES=0).
  - GAP → ADDR with idx+1. After idx=12, go to RESTORE instead.
  - RESTORE → DONE.
  - DONE → IDLE; idx and pending are cleared.
- Latency with GAP_CYCLES=1:
  - Acceptance cycle is T0; first ADDR is T1; entry k ADDR is at T1+3k.
  - RESTORE at T40, done=1 at T41, IDLE at T42.
  - General formula: done at T0 + 13*(2+GAP_CYCLES) + 2.
- While busy:
  - host_wait=1 and crtc_lock=0, so locked registers R0–R9 are writable.
  - Host strobes are blocked from the CRTC, and shadow is not updated.
- crtc_read is 0 in every non-IDLE state.
- Reset mid-load: the sequence aborts immediately with the reset values above. The CRTC is left partially programmed; no recovery is attempted.
- Mode table (R0..R7, R9, R10, R11):
  - mode 0 (MDA 80x25): 97,80,82,15,25,6,25,25,13,11,12
  - mode 1 (CGA 40x25): 56,40,45,10,31,6,25,28,7,6,7
  - mode 2 (CGA 80x25): 113,80,90,10,31,6,25,28,7,6,7
  - mode 3 (CGA graphics): 56,40,45,10,127,6,100,112,1,6,7

Decomposition:
- Package crtc_mode_pkg holds:
  - the state enum;
  - the register-order constant array (0..7, 9..13);
  - the 4×13 mode table as 8-bit constants;
  - NUM_LOAD_REGS=13.
- Sub-module crtc_mode_rom (combinational): mode and idx in, 8-bit value out; entries 11 and 12 return 0.

Test Plan:
- Reset, then start with mode_sel=0 → crtc bus shows pairs (0,97),(1,80),(2,82),(3,15),(4,25),(5,6),(6,25),(7,25),(9,13),(10,11),(11,12),(12,0),(13,0); the CRTC model's registers match; done at T41.
- Host address write of index 14, then start with mode 2 → RESTORE drives a0=0, bus=14; a subsequent host data write 0x55 lands in R14.
- host_lock=1, then load mode 3 → crtc_lock=0 during busy; the model's R4 reads back 127 and R6 reads back 100; after done, crtc_lock=1.
- start asserted while host_cs=1 → load begins the cycle after host_cs falls; host write data reaches the CRTC unaltered in the start cycle.
- Host write during busy → host_wait=1, no crtc strobes from the host; the host write completes once IDLE passthrough resumes.
- reset_n low at T20 → busy=0, all strobes 0 asynchronously; a fresh start after release reloads fully, with done at T41.

Source files
------------

// File: rtl/crtc_mode_pkg.sv
// Shared types, register order and mode timing table for the CRTC mode loader.
package crtc_mode_pkg;
   localparam int NUM_LOAD_REGS   = 13;
   localparam int NUM_TABLE_MODES = 4;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DATA, S_GAP, S_RESTORE, S_DONE
   } state_e;

   typedef struct packed {
      logic       cs;
      logic       a0;
      logic       write;
      logic       read;
      logic [7:0] bus;
   } crtc_req_t;

   // R8 (interlace) is deliberately left to the host.
   localparam logic [3:0] REG_ORDER [NUM_LOAD_REGS] = '{
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13
   };

   localparam logic [7:0] MODE_TABLE [NUM_TABLE_MODES][NUM_LOAD_REGS] = '{
      '{8'd97,  8'd80, 8'd82, 8'd15, 8'd25,  8'd6, 8'd25,  8'd25,  8'd13, 8'd11, 8'd12, 8'd0, 8'd0},
      '{8'd56,  8'd40, 8'd45, 8'd10, 8'd31,  8'd6, 8'd25,  8'd28,  8'd7,  8'd6,  8'd7,  8'd0, 8'd0},
      '{8'd113, 8'd80, 8'd90, 8'd10, 8'd31,  8'd6, 8'd25,  8'd28,  8'd7,  8'd6,  8'd7,  8'd0, 8'd0},
      '{8'd56,  8'd40, 8'd45, 8'd10, 8'd127, 8'd6, 8'd100, 8'd112, 8'd1,  8'd6,  8'd7,  8'd0, 8'd0}
   };

   function automatic logic [3:0] reg_of(input logic [3:0] idx);
      return (int'(idx) < NUM_LOAD_REGS) ? REG_ORDER[idx] : 4'd0;
   endfunction
endpackage

// File: rtl/crtc_mode_rom.sv
// Mode table lookup: value written to the CRTC for load entry idx of a mode.
module crtc_mode_rom
   import crtc_mode_pkg::*;
#(
   parameter int MW = 2
) (
   input  logic [MW-1:0] mode,
   input  logic [3:0]    idx,
   output logic [7:0]    value
);

   // Start addresses (R12/R13) always load as zero.
   always_comb begin
      value = 8'd0;
      if (int'(mode) < NUM_TABLE_MODES && int'(idx) < NUM_LOAD_REGS - 2)
         value = MODE_TABLE[mode][idx];
   end

endmodule

// File: rtl/crtc_mode_loader.sv
// Programs CRTC timing registers from the mode table, muxing with host ISA traffic
// and restoring the host-selected address register when finished.
module crtc_mode_loader
   import crtc_mode_pkg::*;
#(
   parameter int GAP_CYCLES = 1,
   parameter int NUM_MODES  = 4,
   localparam int MW        = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [MW-1:0] mode_sel,
   input  logic          host_cs,
   input  logic          host_a0,
   input  logic          host_write,
   input  logic          host_read,
   input  logic [7:0]    host_bus,
   input  logic          host_lock,
   output logic          host_wait,
   output logic          crtc_cs,
   output logic          crtc_a0,
   output logic          crtc_write,
   output logic          crtc_read,
   output logic [7:0]    crtc_bus,
   output logic          crtc_lock,
   output logic          busy,
   output logic          done
);

   state_e          state_q, state_d;
   logic [3:0]      idx_q;
   logic [2:0]      gap_cnt_q;
   logic [4:0]      shadow_q;
   logic            pending_q;
   logic [MW-1:0]   mode_q;
   logic [7:0]      rom_val;
   logic            last_entry;
   logic            gap_end;
   crtc_req_t       req;

   crtc_mode_rom #(.MW(MW)) u_rom (
      .mode  (mode_q),
      .idx   (idx_q),
      .value (rom_val)
   );

   assign last_entry = (idx_q == 4'(NUM_LOAD_REGS - 1));
   assign gap_end    = (int'(gap_cnt_q) == GAP_CYCLES - 1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         gap_cnt_q <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         mode_q    <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  pending_q <= 1'b1;
                  mode_q    <= mode_sel;
               end
               if (host_cs && host_write && !host_a0)
                  shadow_q <= host_bus[4:0];
            end
            S_DATA: begin
               gap_cnt_q <= '0;
               if (GAP_CYCLES == 0) idx_q <= idx_q + 4'd1;
            end
            S_GAP: begin
               if (gap_end) idx_q <= idx_q + 4'd1;
               else         gap_cnt_q <= gap_cnt_q + 3'd1;
            end
            S_DONE: begin
               idx_q     <= '0;
               pending_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // A host access in the acceptance cycle is passed through; the load follows next cycle.
   always_comb begin
      state_d   = state_q;
      req       = '0;
      crtc_lock = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            req       = '{cs: host_cs, a0: host_a0, write: host_write, read: host_read, bus: host_bus};
            crtc_lock = host_lock;
            if ((pending_q || start) && !host_cs) state_d = S_ADDR;
         end
         S_ADDR: begin
            req     = '{cs: 1'b1, a0: 1'b0, write: 1'b1, read: 1'b0, bus: {4'b0, reg_of(idx_q)}};
            state_d = S_DATA;
         end
         S_DATA: begin
            req = '{cs: 1'b1, a0: 1'b1, write: 1'b1, read: 1'b0, bus: rom_val};
            if (GAP_CYCLES != 0) state_d = S_GAP;
            else                 state_d = last_entry ? S_RESTORE : S_ADDR;
         end
         S_GAP: begin
            if (gap_end) state_d = last_entry ? S_RESTORE : S_ADDR;
         end
         S_RESTORE: begin
            req     = '{cs: 1'b1, a0: 1'b0, write: 1'b1, read: 1'b0, bus: {3'b0, shadow_q}};
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign crtc_cs    = req.cs;
   assign crtc_a0    = req.a0;
   assign crtc_write = req.write;
   assign crtc_read  = req.read;
   assign crtc_bus   = req.bus;
   assign busy       = (state_q != S_IDLE);
   assign host_wait  = busy;
   assign done       = (state_q == S_DONE);

endmodule
